control_unit: RTL

Hardwired sequencer that drives every control input of `ALUSystem` (RF, ALU, ARF, IR, memory and mux selects) from a 16-bit instruction. Sits directly upstream of `ALUSystem` inside `System`. Consumes `IROut` and `ALUOutFlag` back from it. Fetches two instruction bytes through PC, decodes, and executes in 1–2 cycles.

---
 rtl/control_unit_pkg.sv | 80 ++++++++
 rtl/control_unit_sequence_counter.sv | 21 ++
 rtl/control_unit.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/control_unit_pkg.sv
// Shared encodings for the hardwired control unit: opcodes, sequence states,
// select/function codes and the idle control vector.
package cu_pkg;

    typedef enum logic [3:0] {
        OpLd  = 4'h0, OpLdm = 4'h1, OpSt  = 4'h2, OpMov = 4'h3,
        OpAdd = 4'h4, OpSub = 4'h5, OpAnd = 4'h6, OpOr  = 4'h7,
        OpNot = 4'h8, OpInc = 4'h9, OpDec = 4'hA, OpBra = 4'hB,
        OpBne = 4'hC, OpBeq = 4'hD, OpNop = 4'hE, OpHlt = 4'hF
    } opcode_t;

    typedef enum logic [2:0] {
        StT0   = 3'd0,
        StT1   = 3'd1,
        StT2   = 3'd2,
        StT3   = 3'd3,
        StHalt = 3'd4
    } tState_t;

    localparam logic [1:0] FunDec   = 2'b00;
    localparam logic [1:0] FunInc   = 2'b01;
    localparam logic [1:0] FunLoad  = 2'b10;
    localparam logic [1:0] FunClear = 2'b11;

    localparam logic [1:0] ArfAr     = 2'b00;
    localparam logic [1:0] ArfSp     = 2'b01;
    localparam logic [1:0] ArfPcPast = 2'b10;
    localparam logic [1:0] ArfPc     = 2'b11;

    // ARF write enables are active-low, MSB-first: {AR, SP, PC}
    localparam logic [2:0] ArfEnAr   = 3'b011;
    localparam logic [2:0] ArfEnSp   = 3'b101;
    localparam logic [2:0] ArfEnPc   = 3'b110;
    localparam logic [2:0] ArfEnNone = 3'b111;

    localparam logic [1:0] MuxAluOut = 2'b00;
    localparam logic [1:0] MuxMemOut = 2'b01;
    localparam logic [1:0] MuxIrLow  = 2'b10;
    localparam logic [1:0] MuxArfC   = 2'b11;

    localparam logic [3:0] AluPassA = 4'b0000;
    localparam logic [3:0] AluNotA  = 4'b0010;
    localparam logic [3:0] AluAdd   = 4'b0100;
    localparam logic [3:0] AluSub   = 4'b0101;
    localparam logic [3:0] AluAnd   = 4'b0111;
    localparam logic [3:0] AluOr    = 4'b1000;

    typedef struct packed {
        logic [1:0] rfOutASel;
        logic [1:0] rfOutBSel;
        logic [1:0] rfFunSel;
        logic [3:0] rfRegSel;
        logic [3:0] aluFunSel;
        logic [1:0] arfOutCSel;
        logic [1:0] arfOutDSel;
        logic [1:0] arfFunSel;
        logic [2:0] arfRegSel;
        logic       irLH;
        logic       irEnable;
        logic [1:0] irFunsel;
        logic       memWR;
        logic       memCS;
        logic [1:0] muxASel;
        logic [1:0] muxBSel;
        logic       muxCSel;
    } ctrlVec_t;

    localparam ctrlVec_t CtrlDefault = '{
        rfOutASel: 2'b00, rfOutBSel: 2'b00, rfFunSel: 2'b00, rfRegSel: 4'b1111,
        aluFunSel: 4'b0000, arfOutCSel: 2'b00, arfOutDSel: 2'b00, arfFunSel: 2'b00,
        arfRegSel: 3'b111, irLH: 1'b0, irEnable: 1'b0, irFunsel: 2'b00,
        memWR: 1'b0, memCS: 1'b1, muxASel: 2'b00, muxBSel: 2'b00, muxCSel: 1'b0
    };

    // RF write enables are active-low, MSB-first: {R0, R1, R2, R3}
    function automatic logic [3:0] rfSelect(input logic [1:0] idx);
        return ~(4'b1000 >> idx);
    endfunction

endpackage

// File: rtl/control_unit_sequence_counter.sv
// 3-bit instruction phase counter; clear wins over hold, hold wins over increment.
module sequence_counter (
    input  logic       Clock,
    input  logic       RESET_N,
    input  logic       inc,
    input  logic       clr,
    input  logic       hold,
    output logic [2:0] count
);

    always_ff @(posedge Clock or negedge RESET_N) begin
        if (!RESET_N) begin
            count <= 3'd0;
        end else if (clr) begin
            count <= 3'd0;
        end else if (!hold && inc) begin
            count <= count + 3'd1;
        end
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired sequencer driving every ALUSystem control input from IROut.
// Optional macro CU_HALT_EN turns opcode F into a HALT that holds until reset.
module control_unit
    import cu_pkg::*;
(
    input  logic        Clock,
    input  logic        RESET_N,
    input  logic [15:0] IROut,
    input  logic [3:0]  ALUOutFlag,
    output logic [1:0]  RF_OutASel,
    output logic [1:0]  RF_OutBSel,
    output logic [1:0]  RF_FunSel,
    output logic [3:0]  RF_RegSel,
    output logic [3:0]  ALU_FunSel,
    output logic [1:0]  ARF_OutCSel,
    output logic [1:0]  ARF_OutDSel,
    output logic [1:0]  ARF_FunSel,
    output logic [2:0]  ARF_RegSel,
    output logic        IR_LH,
    output logic        IR_Enable,
    output logic [1:0]  IR_Funsel,
    output logic        Mem_WR,
    output logic        Mem_CS,
    output logic [1:0]  MuxASel,
    output logic [1:0]  MuxBSel,
    output logic        MuxCSel,
    output logic        Halted
);

    logic [2:0] tCount;
    tState_t    tState;
    opcode_t    op;
    logic [1:0] rd;
    logic [1:0] rs;
    logic       zFlag;
    logic       seqInc;
    logic       seqClr;
    logic       seqHold;
    ctrlVec_t   cv;
    logic       unusedBits;

    assign tState     = tState_t'(tCount);
    assign op         = opcode_t'(IROut[15:12]);
    assign rd         = IROut[11:10];
    assign rs         = IROut[9:8];
    assign zFlag      = ALUOutFlag[3];
    assign unusedBits = ^{IROut[7:0], ALUOutFlag[2:0]};

    sequence_counter seqCounter (
        .Clock   (Clock),
        .RESET_N (RESET_N),
        .inc     (seqInc),
        .clr     (seqClr),
        .hold    (seqHold),
        .count   (tCount)
    );

    // Every cycle starts from the idle vector; each phase overrides only what it drives.
    always_comb begin
        cv      = CtrlDefault;
        seqInc  = 1'b0;
        seqClr  = 1'b0;
        seqHold = 1'b0;
        if (RESET_N) begin
            case (tState)
                StT0, StT1: begin
                    cv.arfOutDSel = ArfPc;
                    cv.memCS      = 1'b0;
                    cv.irEnable   = 1'b1;
                    cv.irFunsel   = FunLoad;
                    cv.irLH       = (tState == StT1);
                    cv.arfRegSel  = ArfEnPc;
                    cv.arfFunSel  = FunInc;
                    seqInc        = 1'b1;
                end
                StT2: begin
                    seqClr = 1'b1;
                    case (op)
                        OpLd: begin
                            cv.muxASel  = MuxIrLow;
                            cv.rfFunSel = FunLoad;
                            cv.rfRegSel = rfSelect(rd);
                        end
                        OpLdm, OpSt: begin
                            cv.muxBSel   = MuxIrLow;
                            cv.arfFunSel = FunLoad;
                            cv.arfRegSel = ArfEnAr;
                            seqClr       = 1'b0;
                            seqInc       = 1'b1;
                        end
                        OpMov, OpNot: begin
                            cv.rfOutASel = rs;
                            cv.aluFunSel = (op == OpNot) ? AluNotA : AluPassA;
                            cv.muxASel   = MuxAluOut;
                            cv.rfFunSel  = FunLoad;
                            cv.rfRegSel  = rfSelect(rd);
                        end
                        OpAdd, OpSub, OpAnd, OpOr: begin
                            cv.rfOutASel = rd;
                            cv.rfOutBSel = rs;
                            cv.aluFunSel = (op == OpAdd) ? AluAdd :
                                           (op == OpSub) ? AluSub :
                                           (op == OpAnd) ? AluAnd : AluOr;
                            cv.muxASel   = MuxAluOut;
                            cv.rfFunSel  = FunLoad;
                            cv.rfRegSel  = rfSelect(rd);
                        end
                        OpInc, OpDec: begin
                            cv.rfFunSel = (op == OpInc) ? FunInc : FunDec;
                            cv.rfRegSel = rfSelect(rd);
                        end
                        OpBra, OpBne, OpBeq: begin
                            if (op == OpBra || (op == OpBne && !zFlag) ||
                                (op == OpBeq && zFlag)) begin
                                cv.muxBSel   = MuxIrLow;
                                cv.arfFunSel = FunLoad;
                                cv.arfRegSel = ArfEnPc;
                            end
                        end
`ifdef CU_HALT_EN
                        OpHlt: begin
                            seqClr = 1'b0;
                            seqInc = 1'b1;
                        end
`endif
                        default: ;
                    endcase
                end
                StT3: begin
                    seqClr = 1'b1;
                    case (op)
                        OpLdm: begin
                            cv.arfOutDSel = ArfAr;
                            cv.memCS      = 1'b0;
                            cv.muxASel    = MuxMemOut;
                            cv.rfFunSel   = FunLoad;
                            cv.rfRegSel   = rfSelect(rd);
                        end
                        OpSt: begin
                            cv.arfOutDSel = ArfAr;
                            cv.rfOutASel  = rd;
                            cv.muxCSel    = 1'b0;
                            cv.aluFunSel  = AluPassA;
                            cv.memWR      = 1'b1;
                            cv.memCS      = 1'b0;
                        end
`ifdef CU_HALT_EN
                        // HALT is reached by counting T3 -> 4, so the counter needs no load path
                        OpHlt: begin
                            seqClr = 1'b0;
                            seqInc = 1'b1;
                        end
`endif
                        default: ;
                    endcase
                end
                StHalt: seqHold = 1'b1;
                default: seqClr = 1'b1;
            endcase
        end
    end

    assign RF_OutASel  = cv.rfOutASel;
    assign RF_OutBSel  = cv.rfOutBSel;
    assign RF_FunSel   = cv.rfFunSel;
    assign RF_RegSel   = cv.rfRegSel;
    assign ALU_FunSel  = cv.aluFunSel;
    assign ARF_OutCSel = cv.arfOutCSel;
    assign ARF_OutDSel = cv.arfOutDSel;
    assign ARF_FunSel  = cv.arfFunSel;
    assign ARF_RegSel  = cv.arfRegSel;
    assign IR_LH       = cv.irLH;
    assign IR_Enable   = cv.irEnable;
    assign IR_Funsel   = cv.irFunsel;
    assign Mem_WR      = cv.memWR;
    assign Mem_CS      = cv.memCS;
    assign MuxASel     = cv.muxASel;
    assign MuxBSel     = cv.muxBSel;
    assign MuxCSel     = cv.muxCSel;

`ifdef CU_HALT_EN
    assign Halted = (tState == StHalt);
`else
    assign Halted = 1'b0;
`endif

endmodule
